// File: rtl/booth_ctrl.sv
// Radix-2 Booth multiplier control sequencer: emits one-hot datapath strobes c0-c6.
// Busy for 5 + 2N + k cycles per operation (k = add/subtract steps); start is ignored while busy.
module booth_ctrl #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 start,
  input  logic                 q0,
  input  logic                 q_m1,
  output logic                 c0,
  output logic                 c1,
  output logic                 c2,
  output logic                 c3,
  output logic                 c4,
  output logic                 c5,
  output logic                 c6,
  output logic                 busy,
  output logic                 done,
  output logic [$clog2(N)-1:0] cnt
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_LOADM,
    S_TEST,
    S_ADD,
    S_SUB,
    S_SHIFT,
    S_OUTA,
    S_OUTQ,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_INIT;
      S_INIT:  state_nxt = S_LOADM;
      S_LOADM: state_nxt = S_TEST;
      S_TEST: begin
        case ({q0, q_m1})
          2'b10:   state_nxt = S_SUB;
          2'b01:   state_nxt = S_ADD;
          default: state_nxt = S_SHIFT;
        endcase
      end
      S_ADD:   state_nxt = S_SHIFT;
      S_SUB:   state_nxt = S_SHIFT;
      S_SHIFT: state_nxt = (cnt == LAST) ? S_OUTA : S_TEST;
      S_OUTA:  state_nxt = S_OUTQ;
      S_OUTQ:  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state, so each one is a clean decode of the state register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= S_IDLE;
      cnt   <= '0;
      c0    <= 1'b0;
      c1    <= 1'b0;
      c2    <= 1'b0;
      c3    <= 1'b0;
      c4    <= 1'b0;
      c5    <= 1'b0;
      c6    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      c0    <= (state_nxt == S_INIT);
      c1    <= (state_nxt == S_LOADM);
      c2    <= (state_nxt == S_ADD);
      c3    <= (state_nxt == S_SUB);
      c4    <= (state_nxt == S_SHIFT);
      c5    <= (state_nxt == S_OUTQ);
      c6    <= (state_nxt == S_OUTA);
      busy  <= (state_nxt != S_IDLE);
      done  <= (state_nxt == S_DONE);
      case (state)
        S_IDLE:  cnt <= '0;
        S_INIT:  cnt <= '0;
        S_SHIFT: cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_ctrl.sv
// Bench for booth_ctrl: a register datapath around the DUT plus a Booth-recoding model of the expected strobe stream.
module tb_booth_ctrl;

  logic       clk, rst_b, start;
  logic       c0, c1, c2, c3, c4, c5, c6, busy, done;
  logic [2:0] cnt;
  logic       q0, q_m1;

  booth_ctrl #(.N(8)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .q0(q0), .q_m1(q_m1),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6),
    .busy(busy), .done(done), .cnt(cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register datapath driven by the strobes
  logic [7:0] A = 8'h00, Q = 8'h00, M = 8'h00;
  logic       qm1 = 1'b0;
  logic [7:0] op_q = 8'h00, op_m = 8'h00;
  wire  [7:0] obus = c6 ? A : (c5 ? Q : 8'bz);
  assign q0   = Q[0];
  assign q_m1 = qm1;

  always @(posedge clk) begin
    if (c0) begin A <= 8'h00; Q <= op_q; qm1 <= 1'b0; end
    if (c1) M <= op_m;
    if (c2) A <= A + M;
    if (c3) A <= A - M;
    if (c4) {A, Q, qm1} <= {A[7], A, Q};
  end

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected per-cycle output: strb = {done,c6,c5,c4,c3,c2,c1,c0}
  typedef struct {
    logic [7:0] strb;
    logic       bsy;
    logic [2:0] cn;
    logic       ochk;
    logic [7:0] ob;
  } ent_t;

  ent_t exp_q[$];
  logic chk_en = 1'b0;

  function automatic ent_t mk(input logic [7:0] s, input logic b, input logic [2:0] c,
                              input logic oc, input logic [7:0] o);
    ent_t e;
    e.strb = s; e.bsy = b; e.cn = c; e.ochk = oc; e.ob = o;
    return e;
  endfunction

  // Booth recoding of the multiplier bits yields the op list; product comes from plain signed arithmetic.
  task automatic push_op(input logic [7:0] m, input logic [7:0] q);
    logic [15:0] p;
    logic        prev;
    p    = {{8{m[7]}}, m} * {{8{q[7]}}, q};
    prev = 1'b0;
    exp_q.push_back(mk(8'h01, 1'b1, 3'd0, 1'b0, 8'h00));
    exp_q.push_back(mk(8'h02, 1'b1, 3'd0, 1'b0, 8'h00));
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(mk(8'h00, 1'b1, 3'(i), 1'b0, 8'h00));
      if (q[i] && !prev)      exp_q.push_back(mk(8'h08, 1'b1, 3'(i), 1'b0, 8'h00));
      else if (!q[i] && prev) exp_q.push_back(mk(8'h04, 1'b1, 3'(i), 1'b0, 8'h00));
      exp_q.push_back(mk(8'h10, 1'b1, 3'(i), 1'b0, 8'h00));
      prev = q[i];
    end
    exp_q.push_back(mk(8'h40, 1'b1, 3'd0, 1'b1, p[15:8]));
    exp_q.push_back(mk(8'h20, 1'b1, 3'd0, 1'b1, p[7:0]));
    exp_q.push_back(mk(8'h80, 1'b1, 3'd0, 1'b0, 8'h00));
  endtask

  task automatic push_idle();
    exp_q.push_back(mk(8'h00, 1'b0, 3'd0, 1'b0, 8'h00));
  endtask

  // Compare process: every cycle, DUT outputs vs model (idle when nothing queued)
  always @(negedge clk) begin
    ent_t e;
    if (chk_en) begin
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else e = mk(8'h00, 1'b0, 3'd0, 1'b0, 8'h00);
      chk("strobes", {8'h00, done, c6, c5, c4, c3, c2, c1, c0}, {8'h00, e.strb});
      chk("busy", {15'h0, busy}, {15'h0, e.bsy});
      chk("cnt", {13'h0, cnt}, {13'h0, e.cn});
      chk("onehot", {15'h0, $onehot0({c0, c1, c2, c3, c4, c5, c6})}, 16'h0001);
      if (e.ochk) chk("obus", {8'h00, obus}, {8'h00, e.ob});
    end
  end

  int n_busy, n_c2, n_c3, n_c4, n_done, n_any, sub_it, add_it;
  logic [7:0] hi_cap, lo_cap;

  task automatic clr_stats();
    n_busy = 0; n_c2 = 0; n_c3 = 0; n_c4 = 0; n_done = 0; n_any = 0;
    sub_it = -1; add_it = -1; hi_cap = 8'h5A; lo_cap = 8'h5A;
  endtask

  always @(negedge clk) begin
    if (busy) n_busy++;
    if (c2) begin n_c2++; add_it = int'(cnt); end
    if (c3) begin n_c3++; sub_it = int'(cnt); end
    if (c4) n_c4++;
    if (done) n_done++;
    if (c0 | c1 | c2 | c3 | c4 | c5 | c6) n_any++;
    if (c6) hi_cap = obus;
    if (c5) lo_cap = obus;
  end

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    chk("drain_timeout", 16'(exp_q.size()), 16'h0000);
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string nm, input logic [7:0] m, input logic [7:0] q,
                        input int e_busy, input int e_c2, input int e_c3, input logic [15:0] e_prod);
    clr_stats();
    op_m = m;
    op_q = q;
    @(posedge clk);
    #1;
    start = 1'b1;
    push_idle();
    push_op(m, q);
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();
    chk({nm, "_busy"}, 16'(n_busy), 16'(e_busy));
    chk({nm, "_c2"}, 16'(n_c2), 16'(e_c2));
    chk({nm, "_c3"}, 16'(n_c3), 16'(e_c3));
    chk({nm, "_c4"}, 16'(n_c4), 16'd8);
    chk({nm, "_done"}, 16'(n_done), 16'd1);
    chk({nm, "_prod"}, {hi_cap, lo_cap}, e_prod);
  endtask

  initial begin
    rst_b = 1'b0;
    start = 1'b0;
    clr_stats();
    #1;
    chk("reset_outputs", {4'h0, cnt, busy, done, c6, c5, c4, c3, c2, c1, c0}, 16'h0000);
    @(posedge clk);
    #1;
    rst_b  = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);

    run_op("zero", 8'h25, 8'h00, 21, 0, 0, 16'h0000);
    run_op("5x3", 8'h05, 8'h03, 23, 1, 1, 16'h000F);
    chk("5x3_sub_iter", 16'(sub_it), 16'd0);
    chk("5x3_add_iter", 16'(add_it), 16'd2);
    run_op("alt", 8'hFD, 8'h55, 29, 4, 4, 16'hFF01);

    // start held for 60 cycles: three back-to-back ops, one IDLE cycle apart
    clr_stats();
    op_m = 8'h25;
    op_q = 8'h00;
    @(posedge clk);
    #1;
    start = 1'b1;
    push_idle();
    for (int k = 0; k < 3; k++) begin
      push_op(8'h25, 8'h00);
      if (k < 2) push_idle();
    end
    repeat (60) @(posedge clk);
    #1;
    start = 1'b0;
    drain();
    repeat (5) @(posedge clk);
    chk("held_done", 16'(n_done), 16'd3);
    chk("held_busy", 16'(n_busy), 16'd63);

    // reset asserted while the ADD strobe is up
    clr_stats();
    op_m = 8'hFD;
    op_q = 8'h55;
    @(posedge clk);
    #1;
    start = 1'b1;
    push_idle();
    push_op(8'hFD, 8'h55);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (c2) break;
      @(posedge clk);
      #1;
    end
    chk("reach_add", {15'h0, c2}, 16'h0001);
    chk_en = 1'b0;
    #2;
    rst_b = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_c2", {15'h0, c2}, 16'h0000);
    chk("rst_busy", {15'h0, busy}, 16'h0000);
    chk("rst_cnt", {13'h0, cnt}, 16'h0000);
    chk("rst_all", {7'h0, done, c6, c5, c4, c3, c2, c1, c0}, 16'h0000);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    clr_stats();
    chk_en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_quiet", 16'(n_any), 16'd0);

    run_op("after_rst", 8'h05, 8'h03, 23, 1, 1, 16'h000F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/booth_ctrl.md
# booth_ctrl

Control sequencer for the radix-2 Booth multiplier datapath. It drives the one-hot-per-cycle control strobes c0–c6 to the A, Q and M registers and to the adder/subtractor. It decides add, subtract or shift from the Q-register LSB pair {q0, q_m1}, and counts N shift iterations. When finished it places A and then Q on the shared output bus and reports completion. It sits between the top-level start/done handshake and the register datapath.

## Interface

- N, default 8: operand width, which is also the iteration count. It must be ≥2.
- clk: input, 1 bit. System clock; all state changes on the rising edge.
- rst_b: input, 1 bit. Reset, asynchronous, active-low.
- start: input, 1 bit. Request a multiplication; sampled only in IDLE.
- q0: input, 1 bit. Current Q-register LSB.
- q_m1: input, 1 bit. Current Q(-1) extension bit.
- c0: output, 1 bit. Init: clear A, load Q from input bus, clear q_m1.
- c1: output, 1 bit. Load M from input bus.
- c2: output, 1 bit. A <= A + M.
- c3: output, 1 bit. A <= A − M.
- c4: output, 1 bit. Arithmetic right shift of A:Q:q_m1.
- c5: output, 1 bit. Drive Q onto obus (low half of the product).
- c6: output, 1 bit. Drive A onto obus (high half of the product).
- busy: output, 1 bit. High in every state except IDLE.
- done: output, 1 bit. One-cycle completion pulse.
- cnt: output, $clog2(N) bits. Number of completed shift iterations.

## Operation

- States: IDLE, INIT, LOADM, TEST, ADD, SUB, SHIFT, OUTA, OUTQ, DONE.
- IDLE: all strobes low, cnt=0. On start=1 go to INIT; otherwise stay.
- INIT: assert c0 and reset cnt to 0. Go to LOADM.
- LOADM: assert c1. Go to TEST.
- TEST: assert no strobes. Decide from {q0,q_m1}:
  - 10 → SUB.
  - 01 → ADD.
  - 00 or 11 → SHIFT.
- ADD: assert c2, then go to SHIFT.
- SUB: assert c3, then go to SHIFT.
- SHIFT: assert c4.
  - If cnt==N−1, go to OUTA and clear cnt to 0.
  - Otherwise increment cnt and go to TEST.
- OUTA: assert c6. Go to OUTQ.
- OUTQ: assert c5. Go to DONE.
- DONE: done=1. Go to IDLE.
- Strobes are pure Moore decodes of the state register. At most one of c0–c6 is high in any cycle.
- In TEST, q0 and q_m1 are sampled at the rising edge that leaves TEST. The datapath guarantees they are settled by then.
- start asserted while busy=1 is ignored, not queued. start held high through DONE begins a new operation on the cycle after DONE.
- cnt wraps only through the explicit clear in SHIFT; it never counts past N−1.

## Timing

- Reset (rst_b=0, any time, including mid-operation) takes effect immediately:
  - state = IDLE;
  - cnt = 0;
  - c0–c6, busy and done all 0.
  - Strobes fall asynchronously with the state register.
- After rst_b rises, the first start can be sampled on the next rising edge.
- Latency: let edge E0 sample start=1 in IDLE.
  - INIT occupies cycle 1 and LOADM occupies cycle 2.
  - Each iteration takes 2 cycles (no operation) or 3 cycles (add or subtract).
  - OUTA, OUTQ and DONE follow, one cycle each.
- Total busy cycles = 5 + 2N + k, where k is the number of add/subtract operations (0 ≤ k ≤ N).
  - For N=8 this ranges from 21 to 29 cycles.
- done is high in the last busy cycle. busy falls on the edge after DONE.
- obus ownership by the datapath: A during OUTA, Q during OUTQ, high-Z otherwise.

## Test plan

- Reset mid-op: assert rst_b=0 while in the ADD state (N=8). Required: c2 and busy drop to 0 immediately, cnt=0, and after release no strobe occurs without a new start.
- Zero multiplier (Q=0x00, M=0x25), bench models the datapath. Required: no c2/c3 pulses, 8 c4 pulses, 21 busy cycles, product 0x0000.
- 5×3 (M=0x05, Q=0x03). Required: strobe sequence c0, c1, then SUB at iteration 1 and ADD at iteration 3, 23 busy cycles, obus shows 0x00 in OUTA then 0x0F in OUTQ, done pulses once.
- Alternating multiplier (Q=0x55, M=0xFD, i.e. −3). Required: 4 c3 and 4 c2 pulses, alternating SUB/ADD, 29 busy cycles, product 0xFF01 (−255).
- start held high for 60 cycles. Required: back-to-back operations with exactly one IDLE cycle between them; start pulses during busy have no effect; strobes are checked one-hot every cycle.
